writeback_stage: RTL

Final stage of the Y86-64 pipeline. It holds the W pipeline register, owns the 15-entry architectural register file, and performs the E and M port writes. It serves combinational register reads to decode and produces the processor status plus a sticky halt flag. Decode's W_* forwarding inputs come from this block's W register outputs.

---
 rtl/writeback_stage_pkg.sv | 22 ++
 rtl/writeback_stage_regfile_2w2r.sv | 37 +++
 rtl/writeback_stage.sv | 73 +++++++
 3 files changed

// File: rtl/writeback_stage_pkg.sv
// writeback_stage_pkg: Y86-64 status codes, register IDs and icodes shared across pipeline stages
package writeback_stage_pkg;
  localparam logic [2:0] STAT_BUB = 3'd0;
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;
  localparam logic [3:0] RRSP = 4'h4;
  localparam logic [3:0] RNONE = 4'hf;
  localparam logic [3:0] IHALT = 4'h0;
  localparam logic [3:0] INOP = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ = 4'h6;
  localparam logic [3:0] IJXX = 4'h7;
  localparam logic [3:0] ICALL = 4'h8;
  localparam logic [3:0] IRET = 4'h9;
  localparam logic [3:0] IPUSHQ = 4'ha;
  localparam logic [3:0] IPOPQ = 4'hb;
endpackage

// File: rtl/writeback_stage_regfile_2w2r.sv
// regfile_2w2r: 15-entry register file, two write ports with M priority, two read ports and an rsp tap
module regfile_2w2r
  import writeback_stage_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int NREG = 15,
  parameter logic [XLEN-1:0] RSP_INIT = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [3:0]      dst_e,
  input  logic [XLEN-1:0] val_e,
  input  logic [3:0]      dst_m,
  input  logic [XLEN-1:0] val_m,
  input  logic [3:0]      src_a,
  input  logic [3:0]      src_b,
  output logic [XLEN-1:0] rval_a,
  output logic [XLEN-1:0] rval_b,
  output logic [XLEN-1:0] val_stk
);
  logic [XLEN-1:0] regs [NREG];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= i == int'(RRSP) ? RSP_INIT : '0;
    end else if (we) begin
      if (dst_e != RNONE)
        regs[dst_e] <= val_e;
      if (dst_m != RNONE)
        regs[dst_m] <= val_m;
    end
  end
  assign rval_a = src_a == RNONE ? '0 : regs[src_a];
  assign rval_b = src_b == RNONE ? '0 : regs[src_b];
  assign val_stk = regs[RRSP];
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: Y86-64 W pipeline register, register file writes, processor status and sticky halt
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int NREG = 15,
  parameter logic [XLEN-1:0] RSP_INIT = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            W_stall,
  input  logic            W_bubble,
  input  logic [2:0]      m_stat,
  input  logic [3:0]      M_icode,
  input  logic [XLEN-1:0] M_valE,
  input  logic [XLEN-1:0] m_valM,
  input  logic [3:0]      M_dstE,
  input  logic [3:0]      M_dstM,
  output logic [2:0]      W_stat,
  output logic [3:0]      W_icode,
  output logic [XLEN-1:0] W_valE,
  output logic [XLEN-1:0] W_valM,
  output logic [3:0]      W_dstE,
  output logic [3:0]      W_dstM,
  input  logic [3:0]      srcA,
  input  logic [3:0]      srcB,
  output logic [XLEN-1:0] rvalA,
  output logic [XLEN-1:0] rvalB,
  output logic [XLEN-1:0] valStk,
  output logic [2:0]      Stat,
  output logic            halted
);
  logic we;
  always_ff @(posedge clk) begin
    if (!rst_n || W_bubble) begin
      W_stat <= STAT_BUB;
      W_icode <= INOP;
      W_valE <= '0;
      W_valM <= '0;
      W_dstE <= RNONE;
      W_dstM <= RNONE;
    end else if (!W_stall) begin
      W_stat <= m_stat;
      W_icode <= M_icode;
      W_valE <= M_valE;
      W_valM <= m_valM;
      W_dstE <= M_dstE;
      W_dstM <= M_dstM;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n)
      halted <= 1'b0;
    else if (W_stat == STAT_HLT || W_stat == STAT_ADR || W_stat == STAT_INS)
      halted <= 1'b1;
  end
  assign we = W_stat == STAT_AOK && !halted;
  assign Stat = W_stat == STAT_BUB ? STAT_AOK : W_stat;
  regfile_2w2r #(.XLEN(XLEN), .NREG(NREG), .RSP_INIT(RSP_INIT)) u_rf (
    .clk(clk),
    .rst_n(rst_n),
    .we(we),
    .dst_e(W_dstE),
    .val_e(W_valE),
    .dst_m(W_dstM),
    .val_m(W_valM),
    .src_a(srcA),
    .src_b(srcB),
    .rval_a(rvalA),
    .rval_b(rvalB),
    .val_stk(valStk)
  );
endmodule
